// File: rtl/ifetch_pcgen.sv
// ifetch_pcgen: PC generation and instruction fetch.
//
// Holds the fetch PC, issues word requests to instruction memory under a
// credit rule that keeps the instruction FIFO from overflowing, buffers
// returned words (with their PCs) in an in-order FIFO toward decode, and
// handles execute-stage redirects: the FIFO is flushed and every response
// still in flight is discarded.
//
// Ports:
//   clk            clock, rising edge
//   reset_n        synchronous reset, active low
//   branch_v_i     redirect request from execute
//   pc_nxt_i       redirect target (valid with branch_v_i)
//   imem_req_o     fetch request valid
//   imem_addr_o    fetch word address, bits [1:0] = 0
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid (in request order)
//   imem_rdata_i   returned instruction word
//   instr_v_o      FIFO head valid toward decode
//   instr_o        FIFO head instruction
//   pc_o           PC of FIFO head instruction
//   dec_ready_i    decode accepts head this cycle
//   misalign_o     last redirect target was not word aligned
module ifetch_pcgen #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            branch_v_i,
  input  logic [XLEN-1:0] pc_nxt_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_v_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_ready_i,
  output logic            misalign_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic            r_misalign;

  logic [31:0]     r_fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] r_pcq [FIFO_DEPTH];
  logic [AW-1:0]   r_pq_wptr;
  logic [AW-1:0]   r_pq_rptr;

  logic [CW+1:0]   w_credit_used;
  logic            w_credit_ok;
  logic            w_issue;
  logic            w_drop_rsp;
  logic            w_keep_rsp;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_flush_drop;

  // r_outstanding counts live (to-be-kept) requests only; requests that
  // must be discarded move into r_drop_cnt on redirect/reset. Their sum is
  // the true number in flight, which also bounds the PC queue.
  always_comb begin
    w_credit_used = {2'b00, r_outstanding} + {2'b00, r_drop_cnt} + {2'b00, r_count};
    w_credit_ok   = w_credit_used < (CW+2)'(FIFO_DEPTH);
    imem_req_o    = reset_n & ~r_misalign & ~branch_v_i & w_credit_ok;
    imem_addr_o   = {r_fetch_pc[XLEN-1:2], 2'b00};
    w_issue       = imem_req_o & imem_gnt_i;
    w_drop_rsp    = imem_rvalid_i & (r_drop_cnt != '0);
    w_keep_rsp    = imem_rvalid_i & (r_drop_cnt == '0);
    w_push        = reset_n & w_keep_rsp & ~branch_v_i;
    instr_v_o     = reset_n & (r_count != '0);
    w_pop         = instr_v_o & dec_ready_i & ~branch_v_i;
    // A response arriving this cycle consumes one of the in-flight slots.
    w_flush_drop  = r_drop_cnt + r_outstanding - CW'(imem_rvalid_i);
    instr_o       = r_fifo_instr[r_rptr];
    pc_o          = r_fifo_pc[r_rptr];
    misalign_o    = r_misalign;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_outstanding <= '0;
      r_drop_cnt    <= w_flush_drop;
      r_misalign    <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_pq_wptr     <= '0;
      r_pq_rptr     <= '0;
    end else if (branch_v_i) begin
      r_fetch_pc    <= {pc_nxt_i[XLEN-1:2], 2'b00};
      r_misalign    <= (pc_nxt_i[1:0] != 2'b00);
      r_outstanding <= '0;
      r_drop_cnt    <= w_flush_drop;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      // The PC queue only tracks live requests, so it is emptied here;
      // dropped responses never need a PC.
      r_pq_wptr     <= '0;
      r_pq_rptr     <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_pq_wptr  <= r_pq_wptr + AW'(1);
      end
      if (w_drop_rsp) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_keep_rsp) r_pq_rptr  <= r_pq_rptr + AW'(1);
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_keep_rsp);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage arrays carry no reset; writes are already gated off in reset
  // and redirect cycles.
  always_ff @(posedge clk) begin
    if (w_issue) r_pcq[r_pq_wptr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_rdata_i;
      r_fifo_pc[r_wptr]    <= r_pcq[r_pq_rptr];
    end
  end

  a_rvalid_legal: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid_i |-> ((r_outstanding != '0) || (r_drop_cnt != '0)));

  a_counter_bound: assert property (@(posedge clk)
    (r_outstanding <= CW'(FIFO_DEPTH)) && (r_drop_cnt <= CW'(FIFO_DEPTH)));

  a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (instr_v_o && !dec_ready_i && !branch_v_i) |=>
      ($stable(instr_o) && $stable(pc_o)));

endmodule

// File: tb/tb_ifetch_pcgen.sv
module tb_ifetch_pcgen;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            branch_v_i;
  logic [XLEN-1:0] pc_nxt_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;
  logic            instr_v_o;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] pc_o;
  logic            dec_ready_i;
  logic            misalign_o;

  ifetch_pcgen #(
    .XLEN(XLEN),
    .FIFO_DEPTH(4),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .branch_v_i(branch_v_i),
    .pc_nxt_i(pc_nxt_i),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .instr_v_o(instr_v_o),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .dec_ready_i(dec_ready_i),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc_q [$];

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } rsp_t;
  rsp_t        rq [$];
  int unsigned cyc = 0;
  int unsigned lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0013 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses, `lat` cycles after the grant.
  initial begin : mem_model
    logic        hs;
    logic        consumed;
    logic [31:0] hs_addr;
    rsp_t        r;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      hs       = imem_req_o && imem_gnt_i;
      hs_addr  = imem_addr_o;
      consumed = imem_rvalid_i;
      @(posedge clk);
      cyc++;
      if (consumed && rq.size() > 0) void'(rq.pop_front());
      if (hs) begin
        r.due  = cyc + lat;
        r.addr = hs_addr;
        rq.push_back(r);
      end
      #1;
      if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(rq[0].addr);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  // Monitor: every accepted FIFO head is compared against the scoreboard.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && instr_v_o && dec_ready_i && !branch_v_i) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc %h instr %h, expected none", pc_o, instr_o);
        end else begin
          e = exp_pc_q.pop_front();
          check("deliver_pc", pc_o, e);
          check("deliver_instr", instr_o, mem_word(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_pc_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_remaining", 32'(exp_pc_q.size()), 32'd0);
    exp_pc_q.delete();
  endtask

  initial begin : main
    reset_n     = 1'b0;
    branch_v_i  = 1'b0;
    pc_nxt_i    = '0;
    imem_gnt_i  = 1'b0;
    dec_ready_i = 1'b1;
    tick(3);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_instr_v", 32'(instr_v_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);

    // Streaming: gnt every cycle for 8 grants, latency 1.
    lat = 1;
    reset_n = 1'b1;
    imem_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) exp_pc_q.push_back(32'(i * 4));
    settle();
    check("t1_req", 32'(imem_req_o), 32'd1);
    tick(1);
    check("t1_v_after_grant", 32'(instr_v_o), 32'd0);
    tick(1);
    check("t1_first_valid", 32'(instr_v_o), 32'd1);
    check("t1_first_pc", pc_o, 32'h0);
    tick(6);
    imem_gnt_i = 1'b0;
    wait_drain(20);
    tick(3);

    // Decode stalled: credit limits to exactly 4 grants.
    reset_n = 1'b0;
    tick(2);
    check("t2_rst_req", 32'(imem_req_o), 32'd0);
    check("t2_rst_v", 32'(instr_v_o), 32'd0);
    dec_ready_i = 1'b0;
    reset_n = 1'b1;
    imem_gnt_i = 1'b1;
    tick(10);
    check("t2_req_blocked", 32'(imem_req_o), 32'd0);
    check("t2_addr_after4", imem_addr_o, 32'h10);
    check("t2_head_pc", pc_o, 32'h0);
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'(i * 4));
    dec_ready_i = 1'b1;
    wait_drain(20);
    tick(3);

    // Redirect to 0x100 with one word buffered and two in flight.
    lat = 3;
    dec_ready_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick(3);
    imem_gnt_i = 1'b0;
    tick(1);
    check("t3_buffered_v", 32'(instr_v_o), 32'd1);
    check("t3_buffered_pc", pc_o, 32'h10);
    branch_v_i = 1'b1;
    pc_nxt_i = 32'h100;
    settle();
    check("t3_no_req_redirect", 32'(imem_req_o), 32'd0);
    tick(1);
    branch_v_i = 1'b0;
    dec_ready_i = 1'b1;
    imem_gnt_i = 1'b1;
    exp_pc_q.push_back(32'h100);
    settle();
    check("t3_flushed", 32'(instr_v_o), 32'd0);
    check("t3_addr", imem_addr_o, 32'h100);
    check("t3_req", 32'(imem_req_o), 32'd1);
    tick(1);
    imem_gnt_i = 1'b0;
    check("t3_addr_next", imem_addr_o, 32'h104);
    wait_drain(20);
    tick(4);

    // Redirect in an rvalid cycle, then a second redirect to 0x200.
    lat = 2;
    imem_gnt_i = 1'b1;
    tick(2);
    imem_gnt_i = 1'b0;
    branch_v_i = 1'b1;
    pc_nxt_i = 32'h300;
    tick(1);
    pc_nxt_i = 32'h200;
    tick(1);
    branch_v_i = 1'b0;
    imem_gnt_i = 1'b1;
    exp_pc_q.push_back(32'h200);
    settle();
    check("t4_addr", imem_addr_o, 32'h200);
    check("t4_req", 32'(imem_req_o), 32'd1);
    check("t4_misalign", 32'(misalign_o), 32'd0);
    tick(1);
    imem_gnt_i = 1'b0;
    wait_drain(20);
    tick(4);

    // Misaligned redirect blocks fetch until a good redirect.
    lat = 1;
    branch_v_i = 1'b1;
    pc_nxt_i = 32'h102;
    tick(1);
    branch_v_i = 1'b0;
    imem_gnt_i = 1'b1;
    settle();
    check("t5_misalign_set", 32'(misalign_o), 32'd1);
    check("t5_req_off", 32'(imem_req_o), 32'd0);
    tick(3);
    check("t5_req_still_off", 32'(imem_req_o), 32'd0);
    check("t5_misalign_held", 32'(misalign_o), 32'd1);
    branch_v_i = 1'b1;
    pc_nxt_i = 32'h40;
    tick(1);
    branch_v_i = 1'b0;
    exp_pc_q.push_back(32'h40);
    settle();
    check("t5_misalign_clr", 32'(misalign_o), 32'd0);
    check("t5_req_on", 32'(imem_req_o), 32'd1);
    check("t5_addr", imem_addr_o, 32'h40);
    tick(1);
    imem_gnt_i = 1'b0;
    wait_drain(20);
    tick(3);

    // Held request without grant, then reset with one request in flight.
    lat = 4;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t6_addr_hold", imem_addr_o, 32'h44);
      check("t6_req_hold", 32'(imem_req_o), 32'd1);
    end
    imem_gnt_i = 1'b1;
    tick(1);
    imem_gnt_i = 1'b0;
    reset_n = 1'b0;
    settle();
    check("t6_rst_req", 32'(imem_req_o), 32'd0);
    check("t6_rst_v", 32'(instr_v_o), 32'd0);
    tick(1);
    reset_n = 1'b1;
    settle();
    check("t6_restart_addr", imem_addr_o, 32'h0);
    check("t6_restart_req", 32'(imem_req_o), 32'd1);
    exp_pc_q.push_back(32'h0);
    imem_gnt_i = 1'b1;
    tick(1);
    imem_gnt_i = 1'b0;
    wait_drain(30);
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
